// File: rtl/tick_sched_pkg.sv
// Shared types and default sizes for the tick scheduler.
//   state_e : scheduler FSM encoding, visible on the state output
//   mode_e  : per-channel tick mode
//   *_DEF   : default parameter values for channel count, counter and tap widths
package tick_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_e;

  typedef enum logic {
    PERIODIC = 1'b0,
    ONESHOT  = 1'b1
  } mode_e;

  localparam int NUM_CH_DEF = 4;
  localparam int CNT_W_DEF  = 32;
  localparam int TAP_W_DEF  = 5;

endpackage

// File: rtl/tick_channel.sv
// One tick channel: holds tap/mode/enable configuration, clears its own
// enable after the first tick in one-shot mode, and registers its tick so
// it lines up with the registered counter value.
// Ports:
//   clk, reset      : clock, async active-low reset
//   wr_i            : accepted config write targeting this channel
//   wr_tap_i/mode/en: values written on wr_i
//   run_d_i         : scheduler will be in RUN next cycle
//   count_d_i       : counter value for next cycle
//   tick_o, en_o    : registered tick pulse and current enable
module tick_channel
  import tick_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int TAP_W = TAP_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_i,
  input  logic [TAP_W-1:0] wr_tap_i,
  input  mode_e            wr_mode_i,
  input  logic             wr_en_i,
  input  logic             run_d_i,
  input  logic [CNT_W-1:0] count_d_i,
  output logic             tick_o,
  output logic             en_o
);

  logic [TAP_W-1:0] tap_q, tap_d;
  mode_e            mode_q, mode_d;
  logic             en_q, en_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] hi_mask, tap_bit;

  // Tick is evaluated against next-cycle values so that the registered
  // pulse appears in the same cycle as the count and config it matched.
  always_comb begin
    tap_d  = tap_q;
    mode_d = mode_q;
    en_d   = en_q;
    if (wr_i) begin
      // A write beats a same-cycle one-shot clear.
      tap_d  = wr_tap_i;
      mode_d = wr_mode_i;
      en_d   = wr_en_i;
    end else if (tick_q && (mode_q == ONESHOT)) begin
      en_d = 1'b0;
    end
    tap_bit = {{(CNT_W-1){1'b0}}, 1'b1} << tap_d;
    // Bits strictly above the tap; shifting twice keeps tap=CNT_W-1 legal.
    hi_mask = ({CNT_W{1'b1}} << tap_d) << 1;
    tick_d  = run_d_i && en_d && ((count_d_i & ~hi_mask) == tap_bit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_q  <= '0;
      mode_q <= PERIODIC;
      en_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      tap_q  <= tap_d;
      mode_q <= mode_d;
      en_q   <= en_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;
  assign en_o   = en_q;

endmodule

// File: rtl/tick_scheduler.sv
// Free-running counter with start/stop sequencing and NUM_CH tap-driven
// tick channels.
// Ports:
//   clk, reset         : clock, async active-low reset
//   start, stop        : run control (stop has priority)
//   cfg_valid/ready    : config write handshake (not ready during SYNC)
//   cfg_ch/tap/mode/en : channel config write payload
//   tick               : per-channel one-cycle pulse aligned with count
//   count              : current counter value
//   ch_en              : per-channel enable
//   state              : current FSM state
//
// state | meaning
// IDLE  | counter holds, no ticks
// SYNC  | single cycle, counter cleared, config writes stalled
// RUN   | counter increments and wraps, channels may tick
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TAP_W  = TAP_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [TAP_W-1:0]          cfg_tap,
  input  logic                      cfg_mode,
  input  logic                      cfg_en,
  output logic [NUM_CH-1:0]         tick,
  output logic [CNT_W-1:0]          count,
  output logic [NUM_CH-1:0]         ch_en,
  output logic [1:0]                state
);

  localparam int CH_W = $clog2(NUM_CH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cfg_acc;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !stop) state_d = SYNC;
      SYNC:    state_d = stop ? IDLE : RUN;
      RUN:     if (stop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Count follows the state it will be shown in.
    count_d = count_q;
    if (state_d == SYNC)     count_d = '0;
    else if (state_d == RUN) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign cfg_ready = (state_q != SYNC);
  assign cfg_acc   = cfg_valid && cfg_ready;

  // Out-of-range cfg_ch matches no channel, so such writes are dropped.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    tick_channel #(
      .CNT_W (CNT_W),
      .TAP_W (TAP_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .wr_i      (cfg_acc && (cfg_ch == CH_W'(c))),
      .wr_tap_i  (cfg_tap),
      .wr_mode_i (mode_e'(cfg_mode)),
      .wr_en_i   (cfg_en),
      .run_d_i   (state_d == RUN),
      .count_d_i (count_d),
      .tick_o    (tick[c]),
      .en_o      (ch_en[c])
    );
  end

  assign count = count_q;
  assign state = state_q;

endmodule

// File: tb/tb_tick_scheduler.sv
module tb_tick_scheduler;
  import tick_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Index 0: default-sized instance, index 1: narrow instance for wrap tests.
  logic       in_start[2], in_stop[2], in_valid[2], in_mode[2], in_en[2];
  logic [1:0] in_ch[2];
  logic [4:0] in_tap[2];

  logic        rdy0, rdy1;
  logic [3:0]  tk0, en0;
  logic [1:0]  tk1, en1;
  logic [31:0] cnt0;
  logic [7:0]  cnt1;
  logic [1:0]  st0, st1;

  tick_scheduler dut (
    .clk(clk), .reset(reset), .start(in_start[0]), .stop(in_stop[0]),
    .cfg_valid(in_valid[0]), .cfg_ready(rdy0), .cfg_ch(in_ch[0]),
    .cfg_tap(in_tap[0]), .cfg_mode(in_mode[0]), .cfg_en(in_en[0]),
    .tick(tk0), .count(cnt0), .ch_en(en0), .state(st0)
  );

  tick_scheduler #(.NUM_CH(2), .CNT_W(8), .TAP_W(3)) dut_s (
    .clk(clk), .reset(reset), .start(in_start[1]), .stop(in_stop[1]),
    .cfg_valid(in_valid[1]), .cfg_ready(rdy1), .cfg_ch(in_ch[1][0]),
    .cfg_tap(in_tap[1][2:0]), .cfg_mode(in_mode[1]), .cfg_en(in_en[1]),
    .tick(tk1), .count(cnt1), .ch_en(en1), .state(st1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, longint unsigned act, longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  state_e          m_state[2];
  longint unsigned m_cnt[2];
  int              m_tap[2][4];
  bit              m_mode[2][4], m_en[2][4], m_tick[2][4];

  function automatic int nch_of(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic longint unsigned wrap_of(int i);
    return (i == 0) ? 64'h1_0000_0000 : 64'h100;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = IDLE;
      m_cnt[i]   = 0;
      for (int c = 0; c < 4; c++) begin
        m_tap[i][c] = 0; m_mode[i][c] = 0; m_en[i][c] = 0; m_tick[i][c] = 0;
      end
    end
  endtask

  task automatic mstep(int i);
    state_e          ns;
    longint unsigned nc, period;
    int              ch, tp;
    bit              acc;
    ns = m_state[i];
    if (m_state[i] == IDLE && in_start[i] && !in_stop[i]) ns = SYNC;
    else if (m_state[i] == SYNC) ns = in_stop[i] ? IDLE : RUN;
    else if (m_state[i] == RUN && in_stop[i]) ns = IDLE;
    if (ns == SYNC)     nc = 0;
    else if (ns == RUN) nc = (m_cnt[i] + 1) % wrap_of(i);
    else                nc = m_cnt[i];
    ch  = (i == 0) ? int'(in_ch[0]) : int'(in_ch[1][0]);
    tp  = (i == 0) ? int'(in_tap[0]) : int'(in_tap[1][2:0]);
    acc = in_valid[i] && (m_state[i] != SYNC);
    for (int c = 0; c < nch_of(i); c++) begin
      if (acc && ch == c) begin
        m_tap[i][c] = tp; m_mode[i][c] = in_mode[i]; m_en[i][c] = in_en[i];
      end else if (m_tick[i][c] && m_mode[i][c]) begin
        m_en[i][c] = 0;
      end
      // Channel fires at count = 2^k (mod 2^(k+1)).
      period = 64'd1 << (m_tap[i][c] + 1);
      m_tick[i][c] = (ns == RUN) && m_en[i][c] && ((nc % period) == period / 2);
    end
    m_state[i] = ns;
    m_cnt[i]   = nc;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) mreset();
    else begin
      mstep(0);
      mstep(1);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [3:0] et0, ee0;
    logic [1:0] et1, ee1;
    for (int c = 0; c < 4; c++) begin et0[c] = m_tick[0][c]; ee0[c] = m_en[0][c]; end
    for (int c = 0; c < 2; c++) begin et1[c] = m_tick[1][c]; ee1[c] = m_en[1][c]; end
    chk("state0", st0, m_state[0]);
    chk("count0", cnt0, m_cnt[0]);
    chk("tick0", tk0, et0);
    chk("ch_en0", en0, ee0);
    chk("ready0", rdy0, m_state[0] != SYNC);
    chk("state1", st1, m_state[1]);
    chk("count1", cnt1, m_cnt[1]);
    chk("tick1", tk1, et1);
    chk("ch_en1", en1, ee1);
    chk("ready1", rdy1, m_state[1] != SYNC);
  end

  // ---------------- stimulus ----------------
  task automatic write(int i, int ch, int tap, bit mode, bit en);
    in_valid[i] = 1'b1;
    in_ch[i]    = 2'(ch);
    in_tap[i]   = 5'(tap);
    in_mode[i]  = mode;
    in_en[i]    = en;
    @(negedge clk);
    in_valid[i] = 1'b0;
  endtask

  task automatic pulse_start(int i);
    in_start[i] = 1'b1;
    @(negedge clk);
    in_start[i] = 1'b0;
  endtask

  task automatic pulse_stop(int i);
    in_stop[i] = 1'b1;
    @(negedge clk);
    in_stop[i] = 1'b0;
  endtask

  initial begin
    int n_t;
    longint unsigned t_at;
    for (int i = 0; i < 2; i++) begin
      in_start[i] = 0; in_stop[i] = 0; in_valid[i] = 0;
      in_ch[i] = 0; in_tap[i] = 0; in_mode[i] = 0; in_en[i] = 0;
    end
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", st0, IDLE);
    chk("rst_count", cnt0, 0);
    chk("rst_ch_en", en0, 0);
    chk("rst_tick", tk0, 0);
    chk("rst_ready", rdy0, 1);
    reset = 1'b1;
    @(negedge clk);

    // ch0 tap0 periodic: ticks on every odd count
    write(0, 0, 0, 0, 1);
    pulse_start(0);
    #1;
    chk("sync_state", st0, SYNC);
    chk("sync_ready", rdy0, 0);
    chk("sync_count", cnt0, 0);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk); #1;
      chk("p0_count", cnt0, n);
      chk("p0_tick", tk0[0], n % 2);
    end
    pulse_stop(0);
    #1;
    chk("stop_state", st0, IDLE);
    chk("stop_count", cnt0, 6);
    chk("stop_tick", tk0, 0);

    // ch1 tap3 one-shot: single tick at count 8
    write(0, 0, 0, 0, 0);
    write(0, 1, 3, 1, 1);
    pulse_start(0);
    n_t = 0; t_at = '1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk); #1;
      if (tk0[1]) begin n_t++; t_at = cnt0; end
    end
    chk("os_ticks", n_t, 1);
    chk("os_at", t_at, 8);
    chk("os_en_after", en0[1], 0);
    pulse_stop(0);

    // start and stop together in IDLE
    in_start[0] = 1; in_stop[0] = 1;
    @(negedge clk);
    in_start[0] = 0; in_stop[0] = 0;
    #1;
    chk("ss_state", st0, IDLE);
    chk("ss_count", cnt0, 30);

    // rewrite tap during the tick cycle
    write(0, 0, 1, 0, 1);
    pulse_start(0);
    @(negedge clk);
    @(negedge clk); #1;
    chk("rw_count2", cnt0, 2);
    chk("rw_tick_old", tk0[0], 1);
    write(0, 0, 2, 0, 1);
    #1;
    chk("rw_count3", cnt0, 3);
    chk("rw_tick3", tk0[0], 0);
    @(negedge clk); #1;
    chk("rw_count4", cnt0, 4);
    chk("rw_tick_new", tk0[0], 1);
    pulse_stop(0);

    // async reset while a tick is showing
    write(0, 0, 0, 0, 1);
    pulse_start(0);
    @(negedge clk); #1;
    chk("pre_rst_tick", tk0[0], 1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_tick", tk0, 0);
    chk("mid_rst_count", cnt0, 0);
    chk("mid_rst_state", st0, IDLE);
    chk("mid_rst_ch_en", en0, 0);
    #1 reset = 1'b1;
    @(negedge clk);

    // narrow instance: top tap across a counter wrap
    write(1, 0, 7, 0, 1);
    pulse_start(1);
    n_t = 0; t_at = '1;
    for (int n = 1; n <= 270; n++) begin
      @(negedge clk); #1;
      if (n == 255) chk("wrap_top", cnt1, 255);
      if (n == 256) begin
        chk("wrap_zero", cnt1, 0);
        chk("wrap_run", st1, RUN);
      end
      if (tk1[0]) begin n_t++; t_at = cnt1; end
    end
    chk("wrap_ticks", n_t, 1);
    chk("wrap_at", t_at, 128);
    pulse_stop(1);

    // randomized traffic on both instances
    for (int k = 0; k < 4000; k++) begin
      for (int i = 0; i < 2; i++) begin
        in_start[i] = ($urandom_range(0, 15) == 0);
        in_stop[i]  = ($urandom_range(0, 39) == 0);
        in_valid[i] = ($urandom_range(0, 5) == 0);
        in_ch[i]    = 2'($urandom_range(0, 3));
        in_tap[i]   = 5'($urandom_range(0, (i == 0) ? 7 : 4));
        in_mode[i]  = 1'($urandom_range(0, 1));
        in_en[i]    = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      in_start[i] = 0; in_stop[i] = 0; in_valid[i] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tick_scheduler.md
TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, number of tick channels.
REQ-002 Parameter CNT_W, default 32, free-running counter width.
REQ-003 Parameter TAP_W, default 5, tap-select width; taps 0..CNT_W-1.
REQ-004 clk  input  1  single clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 start  input  1  request to begin counting.
REQ-007 stop  input  1  request to halt counting.
REQ-008 cfg_valid  input  1  config write request.
REQ-009 cfg_ready  output  1  config write may be accepted.
REQ-010 cfg_ch  input  $clog2(NUM_CH)  channel targeted by the write.
REQ-011 cfg_tap  input  TAP_W  counter bit k driving the channel.
REQ-012 cfg_mode  input  1  0 = periodic, 1 = one-shot.
REQ-013 cfg_en  input  1  channel enable written.
REQ-014 tick  output  NUM_CH  one-cycle enable pulse per channel.
REQ-015 count  output  CNT_W  current counter value.
REQ-016 ch_en  output  NUM_CH  current enable of each channel.
REQ-017 state  output  2  current FSM state encoding.

Function
REQ-018 FSM states are IDLE, SYNC and RUN.
- IDLE: count holds its value.
- SYNC: lasts exactly 1 cycle; count forced to 0.
- RUN: count increments by 1 each cycle.
REQ-019 Transitions:
- IDLE -> SYNC on start=1 with stop=0.
- SYNC -> RUN unconditionally, unless stop=1, which gives SYNC -> IDLE.
- RUN -> IDLE on stop=1.
- start while in RUN or SYNC is ignored.
REQ-020 When start and stop are asserted in the same cycle, stop wins in every state.
REQ-021 count wraps from 2^CNT_W-1 to 0 with no flag and no stall.
REQ-022 tick[c] is registered and aligned with count: it is 1 exactly in a cycle where all of the following hold:
- state==RUN;
- ch_en[c]=1;
- count[k:0] == 2^k, where k = tap[c].
REQ-023 Consequently, periodic tick period = 2^(k+1) cycles.
- k=0: first tick when count=1.
- k=3: ticks at count=8, 24, 40, ...
REQ-024 No tick is produced in IDLE or SYNC, including the cycle in which stop is sampled as RUN exits.
REQ-025 One-shot channel: ch_en[c] clears on the cycle after its first tick; no further ticks.
REQ-026 cfg_ready = 1 in IDLE and RUN, 0 in SYNC.
- A write is accepted on cfg_valid && cfg_ready.
- tap, mode and en for cfg_ch update on the next edge.
REQ-027 A tick in the write cycle uses the old configuration; the new configuration governs from the following cycle.
REQ-028 Same-cycle one-shot auto-clear and accepted write to the same channel: the write wins.
REQ-029 Writes to other channels never disturb a channel's state.
REQ-030 cfg_ch >= NUM_CH is accepted and discarded.

Reset
REQ-031 While reset=0, outputs and registers are forced immediately, independent of clk:
- state=IDLE, count=0, tick=0, ch_en=0;
- all taps=0, all modes periodic;
- cfg_ready=1.
REQ-032 Reset deassertion is synchronized by the consumer of clk; the first active edge after reset=1 evaluates IDLE.
REQ-033 Reset asserted mid-RUN aborts immediately; no tick is emitted after reset falls.

Structure
REQ-034 Shared package tick_sched_pkg holds the following, and both RTL and bench import it:
- the state enum (IDLE, SYNC, RUN);
- the mode enum (PERIODIC, ONESHOT);
- default NUM_CH, CNT_W and TAP_W constants.
REQ-035 One sub-module, tick_channel, instantiated NUM_CH times, holds:
- the per-channel config registers;
- the one-shot clear;
- the match/tick register.
REQ-036 The FSM and counter live in tick_scheduler.

Verification
REQ-037 Scenario: reset, write ch0 tap=0 periodic en, then start -> SYNC for 1 cycle, then tick[0] at count=1, 3, 5, ...
REQ-038 Scenario: write ch1 tap=3 one-shot en, then start -> exactly one tick[1] at count=8; ch_en[1]=0 afterwards; none at count=24.
REQ-039 Scenario: start=stop=1 in IDLE -> state remains IDLE, count unchanged.
REQ-040 Scenario: RUN with ch0 tap=1, rewrite tap=2 in the cycle count=2 -> tick at count=2 (old config), next tick at count=4 (new config).
REQ-041 Scenario: force count to 2^32-2 with tap=31 -> count wraps to 0 and RUN continues; tick at count=2^31 only.
REQ-042 Scenario: reset=0 mid-RUN with a tick pending -> immediately tick=0, count=0, state=IDLE, ch_en=0.
